rr_fl_alloc_arbiter: RTL

Parametrised, work-conserving round-robin arbiter between N memory write controller ports and the single free-list (FL) allocation port. It locks one owner per FL transaction, holds the FL request until FL grants, and returns a registered grant pulse plus the allocated block index to that owner. Idle ports are skipped, so back-to-back allocations are sustained at one per cycle under load.

---
 rtl/rr_fl_alloc_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/rr_fl_alloc_arbiter.sv
// Round-robin arbiter that funnels N write-controller allocation requests onto the single free-list port.
// Latency: request to fl_alloc_req_o 1 cycle from IDLE; FL grant to port grant pulse 1 cycle (registered).
// Backpressure: the FL request is held for the locked owner until FL grants or the owner withdraws.
package mem_pkg;
  localparam int ADDR_W = 8;
endpackage

module rr_fl_alloc_arbiter #(
  parameter  int N      = 4,
  parameter  int ADDR_W = mem_pkg::ADDR_W,
  localparam int PTR_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0]                 fl_alloc_req_i,
  output logic [N-1:0]                 fl_alloc_gnt_o,
  output logic [N-1:0][ADDR_W-1:0]     fl_alloc_block_idx_o,
  output logic                         fl_alloc_req_o,
  input  logic                         fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]            fl_alloc_block_idx_i,
  output logic                         busy_o,
  output logic [PTR_W-1:0]             owner_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d, owner_q, owner_d, ptr_inc;
  logic [N-1:0]             gnt_q, gnt_d, owner_oh, rearb_mask;
  logic [N-1:0][ADDR_W-1:0] idx_q;
  logic                     fl_hit, idle_found, rearb_found;
  logic [PTR_W-1:0]         idle_pick, rearb_pick;

  // First set bit of cand searching start, start+1, ... mod N; MSB of result flags a hit.
  function automatic logic [PTR_W:0] rr_sel(input logic [N-1:0] cand, input logic [PTR_W-1:0] start);
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] j;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = PTR_W'((int'(start) + i) % N);
      if (cand[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign owner_oh = N'(1) << owner_q;
  assign ptr_inc  = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + 1'b1;
  // With a single port the held request is simply re-served, keeping one grant per cycle.
  assign rearb_mask = (N == 1) ? '1 : ~owner_oh;

  assign {idle_found, idle_pick}   = rr_sel(fl_alloc_req_i, ptr_q);
  assign {rearb_found, rearb_pick} = rr_sel(fl_alloc_req_i & rearb_mask, ptr_inc);

  assign fl_alloc_req_o = (state_q == WAIT) && fl_alloc_req_i[owner_q];
  assign fl_hit         = fl_alloc_req_o && fl_alloc_gnt_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (idle_found) begin
          owner_d = idle_pick;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fl_hit) begin
          gnt_d = owner_oh;
          ptr_d = ptr_inc;
          if (rearb_found) owner_d = rearb_pick;
          else             state_d = IDLE;
        end else if (!fl_alloc_req_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      if (fl_hit) idx_q[owner_q] <= fl_alloc_block_idx_i;
    end
  end

  assign fl_alloc_gnt_o       = gnt_q;
  assign fl_alloc_block_idx_o = idx_q;
  assign busy_o               = (state_q == WAIT);
  assign owner_o              = owner_q;

endmodule
